// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state type and iteration count.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  localparam int MDU_ITER  = 32;
  localparam int MDU_CNT_W = $clog2(MDU_ITER);

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate; yields |x| at operand load and
// restores the result sign at the end of an operation.
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (W'(0) - val) : val;

endmodule

// File: rtl/hilo_mdu.sv
// Iterative 32-cycle shift-add multiplier / restoring divider owning the
// architectural HI/LO registers; busy stalls the front end while running.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int AW = 2 * WIDTH;

  mdu_state_e            state;
  logic [MDU_CNT_W-1:0]  cnt;
  logic [1:0]            op_r;
  logic                  sign_a;
  logic                  sign_b;
  logic [WIDTH-1:0]      mcand;
  logic [WIDTH-1:0]      a_raw;
  logic [AW-1:0]         acc;
  logic [AW-1:0]         acc_next;
  logic                  ld_neg_a;
  logic                  ld_neg_b;
  logic [WIDTH-1:0]      abs_a;
  logic [WIDTH-1:0]      abs_b;
  logic [WIDTH-1:0]      quo_fix;
  logic [WIDTH-1:0]      rem_fix;
  logic [AW-1:0]         prod_fix;
  logic [WIDTH:0]        add_sum;
  logic signed [WIDTH:0] trial;

  assign busy     = (state != IDLE);
  assign ld_neg_a = op_is_signed(op) & a[WIDTH-1];
  assign ld_neg_b = op_is_signed(op) & b[WIDTH-1];

  mdu_abs_neg #(.W(WIDTH)) u_abs_a (.val(a), .neg(ld_neg_a), .res(abs_a));
  mdu_abs_neg #(.W(WIDTH)) u_abs_b (.val(b), .neg(ld_neg_b), .res(abs_b));

  mdu_abs_neg #(.W(AW))    u_fix_prod (.val(acc), .neg(sign_a ^ sign_b), .res(prod_fix));
  mdu_abs_neg #(.W(WIDTH)) u_fix_quo  (.val(acc[WIDTH-1:0]), .neg(sign_a ^ sign_b), .res(quo_fix));
  mdu_abs_neg #(.W(WIDTH)) u_fix_rem  (.val(acc[AW-1:WIDTH]), .neg(sign_a), .res(rem_fix));

  // One iteration: acc holds {upper, multiplier} or {remainder, quotient}.
  // The trial difference of a 33-bit shifted remainder fits in 33 bits
  // because the remainder is always below the divisor.
  always_comb begin
    add_sum  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    trial    = signed'(acc[AW-1:WIDTH-1] - {1'b0, mcand});
    acc_next = {add_sum, acc[WIDTH-1:1]};
    if (op_is_div(op_r)) begin
      if (!trial[WIDTH]) acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_next = {acc[AW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mcand  <= '0;
      a_raw  <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            sign_a <= ld_neg_a;
            sign_b <= ld_neg_b;
            a_raw  <= a;
            cnt    <= '0;
            if (op_is_div(op)) begin
              mcand <= abs_b;
              acc   <= {{WIDTH{1'b0}}, abs_a};
            end else begin
              mcand <= abs_a;
              acc   <= {{WIDTH{1'b0}}, abs_b};
            end
            state <= RUN;
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + MDU_CNT_W'(1);
          if (cnt == MDU_CNT_W'(MDU_ITER - 1)) state <= FIX;
        end
        FIX: begin
          if (op_is_div(op_r)) begin
            // |b| == 0 exactly when b == 0; raw dividend goes to HI
            if (mcand == '0) begin
              lo <= '1;
              hi <= a_raw;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: directed corner cases plus random ops
// checked against a plain-arithmetic 64-bit reference model.
module tb_hilo_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int passes = 0;
  int done_seen = 0;
  logic [63:0] exp_q[$];

  hilo_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: {HI, LO} from ordinary 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      2'b00: return sx * sy;
      2'b01: return ux * uy;
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          return {r[31:0], q[31:0]};
        end
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Monitor: compares every done pulse against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: hi %h lo %h with empty queue", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hi", 64'(hi), 64'(e[63:32]));
        check("result_lo", 64'(lo), 64'(e[31:0]));
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] e, input bit disturb);
    int cyc;
    int d0;
    logic [31:0] lo_before;
    logic [31:0] hi_before;
    @(negedge clk);
    lo_before = lo;
    hi_before = hi;
    d0 = done_seen;
    start = 1'b1; op = o; a = x; b = y; mtlo = disturb;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0; a = $urandom; b = $urandom;
    cyc = 0;
    while (busy && cyc < 60) begin
      if (disturb) begin
        if (cyc == 3) check("lo_hold_start_mtlo", 64'(lo), 64'(lo_before));
        if (cyc == 5) begin start = 1'b1; mthi = 1'b1; op = 2'b11; a = 32'hAAAA; end
        if (cyc == 6) begin start = 1'b0; mthi = 1'b0; end
        if (cyc == 8) check("hi_hold_busy_mthi", 64'(hi), 64'(hi_before));
      end
      cyc++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(cyc), 64'd33);
    @(negedge clk);
    check("done_pulses", 64'(done_seen - d0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    int d0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run_op(2'b00, 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340, 1'b1);

    // Register moves in IDLE
    @(negedge clk);
    mtlo = 1'b1; a = 32'h0000_1234;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_idle", 64'(lo), 64'h1234);
    mthi = 1'b1; a = 32'h0000_5555;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle", 64'(hi), 64'h5555);
    check("mthi_lo_untouched", 64'(lo), 64'h1234);

    // Reset during a divide aborts with no result
    d0 = done_seen;
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_seen - d0), 64'd0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       y = 32'h0;
        1:       y = 32'hFFFF_FFFF;
        2:       y = 32'h1;
        3:       y = 32'($urandom_range(2, 100));
        default: y = $urandom;
      endcase
      run_op(o, x, y, model(o, x, y), 1'b0);
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
